// File: rtl/ll_pkg.sv
// Shared types and digit helpers for the digit-serial lunar lander engine.
// Values are ten's-complement BCD: a value is negative when its MS digit is 5..9.
package ll_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [2:0] {
    IDLE,
    P_ALT,
    P_VG,
    P_VT,
    P_FUEL,
    COMMIT,
    DONE
  } state_t;

  function automatic logic is_neg(input bcd_digit_t ms_digit);
    return ms_digit >= 4'd5;
  endfunction

  function automatic bcd_digit_t nines_comp_digit(input bcd_digit_t d);
    return 4'd9 - d;
  endfunction

endpackage

// File: rtl/ll_serial_engine_bcd_digit_alu.sv
// Combinational one-digit BCD adder/subtractor; subtraction adds the nine's complement of b.
module bcd_digit_alu
  import ll_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  input  logic       sub,
  output bcd_digit_t s,
  output logic       co
);

  bcd_digit_t b_eff;
  logic [4:0] raw;
  logic [4:0] adj;

  always_comb begin
    b_eff = sub ? nines_comp_digit(b) : b;
    raw   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, ci};
    adj   = raw - 5'd10;
    co    = (raw > 5'd9);
    s     = co ? adj[3:0] : raw[3:0];
  end

endmodule

// File: rtl/ll_serial_engine.sv
// Digit-serial lunar lander physics step: one shared BCD digit ALU, four passes per tick.
// Optional fuel_low output is built only when LL_FUEL_LOW_EN is defined.
module ll_serial_engine
  import ll_pkg::*;
#(
  parameter int                DIGITS   = 4,
  parameter logic [4*DIGITS-1:0] FUEL     = 'h0800,
  parameter logic [4*DIGITS-1:0] ALTITUDE = 'h0450,
  parameter logic [4*DIGITS-1:0] VELOCITY = 'h0000,
  parameter logic [4*DIGITS-1:0] THRUST   = 'h0005,
  parameter logic [4*DIGITS-1:0] GRAVITY  = 'h0005,
  parameter logic [4*DIGITS-1:0] SAFE_VEL = 'h0030,
  parameter logic [4*DIGITS-1:0] FUEL_LOW = 'h0100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                thrust_wr,
  input  logic [3:0]          thrust_in,
  output logic [4*DIGITS-1:0] alt,
  output logic [4*DIGITS-1:0] vel,
  output logic [4*DIGITS-1:0] fuel,
  output logic [4*DIGITS-1:0] thrust,
  output logic                busy,
  output logic                step_done,
  output logic                land,
  output logic                crash,
`ifdef LL_FUEL_LOW_EN
  output logic                overrun,
  output logic                fuel_low
`else
  output logic                overrun
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);

  function automatic logic [W-1:0] tens_comp(input logic [W-1:0] x);
    logic [W-1:0] r;
    logic         c;
    logic [4:0]   d;
    r = '0;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = {1'b0, nines_comp_digit(x[i*4 +: 4])} + {4'b0000, c};
      if (d == 5'd10) begin
        r[i*4 +: 4] = 4'd0;
        c = 1'b1;
      end else begin
        r[i*4 +: 4] = d[3:0];
        c = 1'b0;
      end
    end
    return r;
  endfunction

  // Negative landing-speed limit; negative values closer to zero compare larger.
  localparam logic [W-1:0] NEG_SAFE = tens_comp(SAFE_VEL);

  state_t      state, state_nx;
  logic [IW-1:0] idx;
  logic [IW+1:0] base;
  logic        carry, ci, co, last_digit;
  logic [W-1:0] a_c, t_r, v_c, f_c, fuel_next;
  bcd_digit_t  thrust_d, th_e, op_a, op_b, sum_d;
  logic        op_sub, a_nonpos, f_nonpos, fuel_nonpos, land_ok;

  assign base        = {idx, 2'b00};
  assign last_digit  = (idx == IW'(DIGITS - 1));
  assign busy        = (state != IDLE) && (state != DONE);
  assign thrust      = {{(W-4){1'b0}}, thrust_d};
  assign a_nonpos    = (a_c == '0) || is_neg(a_c[W-1 -: 4]);
  assign f_nonpos    = (f_c == '0) || is_neg(f_c[W-1 -: 4]);
  assign fuel_nonpos = (fuel == '0) || is_neg(fuel[W-1 -: 4]);
  assign land_ok     = !is_neg(v_c[W-1 -: 4]) || ((SAFE_VEL != '0) && (v_c >= NEG_SAFE));
  assign fuel_next   = f_nonpos ? '0 : f_c;
  assign ci          = (idx == '0) ? op_sub : carry;

  bcd_digit_alu u_alu (
    .a  (op_a),
    .b  (op_b),
    .ci (ci),
    .sub(op_sub),
    .s  (sum_d),
    .co (co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Sequencing and operand selection for the shared digit ALU.
  always_comb begin
    state_nx = state;
    op_a     = 4'd0;
    op_b     = 4'd0;
    op_sub   = 1'b0;
    case (state)
      IDLE:   if (tick) state_nx = P_ALT;
      P_ALT: begin
        op_a = alt[base +: 4];
        op_b = vel[base +: 4];
        if (last_digit) state_nx = P_VG;
      end
      P_VG: begin
        op_a   = vel[base +: 4];
        op_b   = GRAVITY[base +: 4];
        op_sub = 1'b1;
        if (last_digit) state_nx = P_VT;
      end
      P_VT: begin
        op_a = t_r[base +: 4];
        op_b = (idx == '0) ? th_e : 4'd0;
        if (last_digit) state_nx = P_FUEL;
      end
      P_FUEL: begin
        op_a   = fuel[base +: 4];
        op_b   = (idx == '0) ? th_e : 4'd0;
        op_sub = 1'b1;
        if (last_digit) state_nx = COMMIT;
      end
      COMMIT: state_nx = a_nonpos ? DONE : IDLE;
      DONE:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alt       <= ALTITUDE;
      vel       <= VELOCITY;
      fuel      <= FUEL;
      thrust_d  <= THRUST[3:0];
      th_e      <= 4'd0;
      idx       <= '0;
      carry     <= 1'b0;
      a_c       <= '0;
      t_r       <= '0;
      v_c       <= '0;
      f_c       <= '0;
      step_done <= 1'b0;
      land      <= 1'b0;
      crash     <= 1'b0;
      overrun   <= 1'b0;
`ifdef LL_FUEL_LOW_EN
      fuel_low  <= (FUEL < FUEL_LOW);
`endif
    end else begin
      step_done <= 1'b0;
      if (tick && busy) overrun <= 1'b1;
      if (thrust_wr && (thrust_in <= 4'd9) && (state != DONE)) thrust_d <= thrust_in;
      if ((state == IDLE) && tick) begin
        th_e <= fuel_nonpos ? 4'd0 : thrust_d;
        idx  <= '0;
      end
      if ((state == P_ALT) || (state == P_VG) || (state == P_VT) || (state == P_FUEL)) begin
        carry <= co;
        idx   <= last_digit ? '0 : idx + IW'(1);
        case (state)
          P_ALT:   a_c[base +: 4] <= sum_d;
          P_VG:    t_r[base +: 4] <= sum_d;
          P_VT:    v_c[base +: 4] <= sum_d;
          default: f_c[base +: 4] <= sum_d;
        endcase
      end
      // A non-positive altitude ends the flight: zero the motion and classify the touchdown.
      if (state == COMMIT) begin
        step_done <= 1'b1;
        fuel      <= fuel_next;
`ifdef LL_FUEL_LOW_EN
        fuel_low  <= (fuel_next < FUEL_LOW);
`endif
        if (a_nonpos) begin
          alt <= '0;
          vel <= '0;
          if (land_ok) land  <= 1'b1;
          else         crash <= 1'b1;
        end else begin
          alt <= a_c;
          vel <= v_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_ll_serial_engine.sv
// Self-checking bench for ll_serial_engine: four differently parameterised instances, an integer
// reference model per instance, a directed step table and randomized traffic. Honours LL_FUEL_LOW_EN.
module tb_ll_serial_engine;

  localparam int NI   = 4;
  localparam int W    = 16;
  localparam int STEP = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         tick      [NI];
  logic         thrust_wr [NI];
  logic [3:0]   thrust_in [NI];
  logic [W-1:0] alt_o [NI], vel_o [NI], fuel_o [NI], thr_o [NI];
  logic         busy_o [NI], done_o [NI], land_o [NI], crash_o [NI], ovr_o [NI];
`ifdef LL_FUEL_LOW_EN
  logic         flow_o [NI];
`endif

  int vectors = 0;
  int miscompares = 0;

  ll_serial_engine u0 (
    .clk(clk), .rst(rst), .tick(tick[0]), .thrust_wr(thrust_wr[0]), .thrust_in(thrust_in[0]),
    .alt(alt_o[0]), .vel(vel_o[0]), .fuel(fuel_o[0]), .thrust(thr_o[0]), .busy(busy_o[0]),
    .step_done(done_o[0]), .land(land_o[0]), .crash(crash_o[0]), .overrun(ovr_o[0])
`ifdef LL_FUEL_LOW_EN
    , .fuel_low(flow_o[0])
`endif
  );

  ll_serial_engine #(.ALTITUDE(16'h0010), .VELOCITY(16'h9980)) u1 (
    .clk(clk), .rst(rst), .tick(tick[1]), .thrust_wr(thrust_wr[1]), .thrust_in(thrust_in[1]),
    .alt(alt_o[1]), .vel(vel_o[1]), .fuel(fuel_o[1]), .thrust(thr_o[1]), .busy(busy_o[1]),
    .step_done(done_o[1]), .land(land_o[1]), .crash(crash_o[1]), .overrun(ovr_o[1])
`ifdef LL_FUEL_LOW_EN
    , .fuel_low(flow_o[1])
`endif
  );

  ll_serial_engine #(.ALTITUDE(16'h0010), .VELOCITY(16'h9950)) u2 (
    .clk(clk), .rst(rst), .tick(tick[2]), .thrust_wr(thrust_wr[2]), .thrust_in(thrust_in[2]),
    .alt(alt_o[2]), .vel(vel_o[2]), .fuel(fuel_o[2]), .thrust(thr_o[2]), .busy(busy_o[2]),
    .step_done(done_o[2]), .land(land_o[2]), .crash(crash_o[2]), .overrun(ovr_o[2])
`ifdef LL_FUEL_LOW_EN
    , .fuel_low(flow_o[2])
`endif
  );

  ll_serial_engine #(.FUEL(16'h0003)) u3 (
    .clk(clk), .rst(rst), .tick(tick[3]), .thrust_wr(thrust_wr[3]), .thrust_in(thrust_in[3]),
    .alt(alt_o[3]), .vel(vel_o[3]), .fuel(fuel_o[3]), .thrust(thr_o[3]), .busy(busy_o[3]),
    .step_done(done_o[3]), .land(land_o[3]), .crash(crash_o[3]), .overrun(ovr_o[3])
`ifdef LL_FUEL_LOW_EN
    , .fuel_low(flow_o[3])
`endif
  );

  typedef struct {
    int alt, vel, fuel, thrust, th_e, cnt;
    bit step_done, land, crash, overrun, done, flow;
  } mdl_t;

  mdl_t m [NI];

  typedef struct {
    int           thr;
    logic [W-1:0] e_alt, e_vel, e_fuel;
  } vec_t;

  vec_t tbl [6];

  function automatic int wrap(input int x);
    int r;
    r = x % 10000;
    if (r < 0) r += 10000;
    if (r >= 5000) r -= 10000;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           n;
    n = v % 10000;
    if (n < 0) n += 10000;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] x);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(x[i*4 +: 4]);
    if (r >= 5000) r -= 10000;
    return r;
  endfunction

  function automatic mdl_t reset_model(input int i);
    mdl_t r;
    r = '{alt: 450, vel: 0, fuel: 800, thrust: 5, th_e: 0, cnt: 0,
          step_done: 0, land: 0, crash: 0, overrun: 0, done: 0, flow: 0};
    case (i)
      1: begin r.alt = from_bcd(16'h0010); r.vel = from_bcd(16'h9980); end
      2: begin r.alt = from_bcd(16'h0010); r.vel = from_bcd(16'h9950); end
      3: r.fuel = 3;
      default: ;
    endcase
    r.flow = (r.fuel < 100);
    return r;
  endfunction

  // One physics step, from the arithmetic rules: gravity 5, landing speed limit 30.
  function automatic mdl_t commit(input mdl_t s);
    mdl_t r;
    int   a, vc, f;
    r  = s;
    a  = wrap(s.alt + s.vel);
    vc = wrap(wrap(s.vel - 5) + s.th_e);
    f  = wrap(s.fuel - s.th_e);
    r.fuel = (f <= 0) ? 0 : f;
    r.flow = (r.fuel < 100);
    r.step_done = 1;
    if (a <= 0) begin
      r.alt = 0;
      r.vel = 0;
      if (vc >= -30) r.land = 1;
      else           r.crash = 1;
      r.done = 1;
    end else begin
      r.alt = a;
      r.vel = vc;
    end
    return r;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m[i] = reset_model(i);
      end else begin
        m[i].step_done = 0;
        if (!m[i].done) begin
          if (m[i].cnt > 0) begin
            if (tick[i]) m[i].overrun = 1;
            m[i].cnt--;
            if (m[i].cnt == 0) m[i] = commit(m[i]);
          end else if (tick[i]) begin
            m[i].th_e = (m[i].fuel > 0) ? m[i].thrust : 0;
            m[i].cnt  = STEP;
          end
          if (thrust_wr[i] && (thrust_in[i] <= 4'd9)) m[i].thrust = int'(thrust_in[i]);
        end
      end
    end
  endtask

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s[u%0d]: got %h, expected %h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < NI; i++) begin
      chk("alt", i, alt_o[i], to_bcd(m[i].alt));
      chk("vel", i, vel_o[i], to_bcd(m[i].vel));
      chk("fuel", i, fuel_o[i], to_bcd(m[i].fuel));
      chk("thrust", i, thr_o[i], 32'(m[i].thrust));
      chk("busy", i, busy_o[i], m[i].cnt > 0);
      chk("step_done", i, done_o[i], m[i].step_done);
      chk("land", i, land_o[i], m[i].land);
      chk("crash", i, crash_o[i], m[i].crash);
      chk("overrun", i, ovr_o[i], m[i].overrun);
`ifdef LL_FUEL_LOW_EN
      chk("fuel_low", i, flow_o[i], m[i].flow);
`endif
    end
  endtask

  task automatic applyStimulus(input int i, input bit tk, input bit wr, input int tin);
    tick[i]      = tk;
    thrust_wr[i] = wr;
    thrust_in[i] = 4'(tin);
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    checkOutput();
    for (int i = 0; i < NI; i++) begin
      tick[i]      = 1'b0;
      thrust_wr[i] = 1'b0;
    end
  endtask

  int pulses;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) applyStimulus(i, 0, 0, 0);
    for (int i = 0; i < NI; i++) m[i] = reset_model(i);

    tbl[0] = '{5,  16'h0450, 16'h0000, 16'h0795};
    tbl[1] = '{0,  16'h0450, 16'h9995, 16'h0795};
    tbl[2] = '{0,  16'h0445, 16'h9990, 16'h0795};
    tbl[3] = '{9,  16'h0435, 16'h9994, 16'h0786};
    tbl[4] = '{7,  16'h0429, 16'h9996, 16'h0779};
    tbl[5] = '{12, 16'h0425, 16'h9998, 16'h0772};

    run_cycle();
    run_cycle();
    rst = 1'b0;
    chk("rst_alt", 0, alt_o[0], 16'h0450);
    chk("rst_vel", 0, vel_o[0], 16'h0000);
    chk("rst_fuel", 0, fuel_o[0], 16'h0800);
    chk("rst_thrust", 0, thr_o[0], 16'h0005);
    chk("rst_flags", 0, {busy_o[0], done_o[0], land_o[0], crash_o[0], ovr_o[0]}, 0);

    // Directed step table on the default instance: exact 17-cycle latency and values.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 1, tbl[k].thr);
      run_cycle();
      applyStimulus(0, 1, 0, 0);
      run_cycle();
      repeat (STEP - 1) run_cycle();
      chk("tbl_early_done", k, done_o[0], 0);
      chk("tbl_busy", k, busy_o[0], 1);
      run_cycle();
      chk("tbl_done", k, done_o[0], 1);
      chk("tbl_alt", k, alt_o[0], tbl[k].e_alt);
      chk("tbl_vel", k, vel_o[0], tbl[k].e_vel);
      chk("tbl_fuel", k, fuel_o[0], tbl[k].e_fuel);
    end

    // Touchdown corners: soft landing, crash, and fuel clamp on the short-fuel instance.
    applyStimulus(1, 0, 1, 0);
    applyStimulus(2, 0, 1, 0);
    run_cycle();
    applyStimulus(1, 1, 0, 0);
    applyStimulus(2, 1, 0, 0);
    applyStimulus(3, 1, 0, 0);
    run_cycle();
    repeat (STEP) run_cycle();
    chk("land_flag", 1, {land_o[1], crash_o[1]}, 2'b10);
    chk("land_altvel", 1, {alt_o[1], vel_o[1]}, 32'h0);
    chk("crash_flag", 2, {land_o[2], crash_o[2]}, 2'b01);
    chk("crash_altvel", 2, {alt_o[2], vel_o[2]}, 32'h0);
    chk("clamp_fuel", 3, fuel_o[3], 16'h0000);
    chk("clamp_vel", 3, vel_o[3], 16'h0000);

    applyStimulus(1, 1, 1, 7);
    applyStimulus(3, 1, 0, 0);
    pulses = 0;
    run_cycle();
    for (int c = 0; c < STEP + 2; c++) begin
      pulses += int'(done_o[1]);
      run_cycle();
    end
    chk("done_no_step", 1, pulses, 0);
    chk("done_thrust_frozen", 1, thr_o[1], 16'h0000);
    chk("done_no_overrun", 1, ovr_o[1], 0);
    chk("no_fuel_vel", 3, vel_o[3], 16'h9995);
    chk("no_fuel_alt", 3, alt_o[3], 16'h0450);

    // Overrun: second tick four cycles into a step is dropped.
    applyStimulus(0, 1, 0, 0);
    run_cycle();
    pulses = 0;
    for (int c = 0; c < STEP + 8; c++) begin
      if (c == 3) applyStimulus(0, 1, 0, 0);
      run_cycle();
      pulses += int'(done_o[0]);
    end
    chk("overrun_flag", 0, ovr_o[0], 1);
    chk("overrun_one_step", 0, pulses, 1);

    // Reset in the middle of a pass abandons the step.
    applyStimulus(0, 1, 0, 0);
    run_cycle();
    repeat (7) run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    chk("midrst_busy", 0, busy_o[0], 0);
    chk("midrst_vals", 0, {alt_o[0], vel_o[0]}, {16'h0450, 16'h0000});
    chk("midrst_ovr", 0, ovr_o[0], 0);
    pulses = 0;
    for (int c = 0; c < STEP + 3; c++) begin
      run_cycle();
      pulses += int'(done_o[0]);
    end
    chk("midrst_no_step", 0, pulses, 0);

    // Randomized traffic on all instances against the reference model.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NI; i++)
        applyStimulus(i, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                      int'($urandom_range(0, 15)));
      run_cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
